// File: rtl/rail_fence_pkg.sv
// rtl/rail_fence_pkg.sv - shared widths, state encoding and rail period helper for rail_fence_sched
package rail_fence_pkg;

  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;
  localparam int MAX_KEY = 8;
  localparam int KEY_W   = 4;
  localparam int ADDR_W  = 6;
  localparam int POS_W   = LEN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Zigzag period 2*(key-1); zero for a single rail.
  function automatic logic [POS_W-1:0] rail_period(input logic [KEY_W-1:0] key);
    logic [POS_W-1:0] k;
    k = POS_W'(key);
    return (k <= POS_W'(1)) ? '0 : ((k - POS_W'(1)) << 1);
  endfunction

endpackage

// File: rtl/rail_fence_sched_if.sv
// rtl/rail_fence_sched_if.sv - config, input and output stream bundle (cfg_mode present with RAIL_FENCE_ENCRYPT_EN)
interface rail_fence_sched_if;
  import rail_fence_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [LEN_W-1:0]  cfg_len;
  logic [KEY_W-1:0]  cfg_key;
  logic              cfg_err;
`ifdef RAIL_FENCE_ENCRYPT_EN
  logic              cfg_mode;
`endif
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport master (
`ifdef RAIL_FENCE_ENCRYPT_EN
    output cfg_mode,
`endif
    output cfg_valid, cfg_len, cfg_key, in_valid, in_data, out_ready,
    input  cfg_ready, cfg_err, in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
`ifdef RAIL_FENCE_ENCRYPT_EN
    input  cfg_mode,
`endif
    input  cfg_valid, cfg_len, cfg_key, in_valid, in_data, out_ready,
    output cfg_ready, cfg_err, in_ready, out_valid, out_data, out_last, busy
  );

endinterface

// File: rtl/rail_pos_gen.sv
// rtl/rail_pos_gen.sv - zigzag buffer position generator walking rail by rail
module rail_pos_gen
  import rail_fence_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [KEY_W-1:0] key,
  input  logic             adv,
  output logic [POS_W-1:0] pos
);

  logic [KEY_W-1:0] rail_q, rail_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             phase_q, phase_d;
  logic [POS_W-1:0] period, step, nxt, rail_x2;

  // Step selection and rail wrap: edge rails step by the full period, middle rails alternate.
  always_comb begin
    rail_d  = rail_q;
    pos_d   = pos_q;
    phase_d = phase_q;
    period  = rail_period(key);
    rail_x2 = POS_W'(rail_q) << 1;
    if (key <= KEY_W'(1)) begin
      step = POS_W'(1);
    end else if ((rail_q == '0) || (rail_q == key - KEY_W'(1))) begin
      step = period;
    end else if (!phase_q) begin
      step = period - rail_x2;
    end else begin
      step = rail_x2;
    end
    nxt = pos_q + step;
    if (start) begin
      rail_d  = '0;
      pos_d   = '0;
      phase_d = 1'b0;
    end else if (adv) begin
      if (nxt >= {1'b0, len}) begin
        rail_d  = rail_q + KEY_W'(1);
        pos_d   = POS_W'(rail_q) + POS_W'(1);
        phase_d = 1'b0;
      end else begin
        pos_d   = nxt;
        phase_d = ~phase_q;
      end
    end
  end

  // Generator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rail_q  <= '0;
      pos_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      rail_q  <= rail_d;
      pos_q   <= pos_d;
      phase_q <= phase_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/rail_fence_sched.sv
// rtl/rail_fence_sched.sv - rail-fence scatter/drain controller (encrypt mode with RAIL_FENCE_ENCRYPT_EN)
module rail_fence_sched
  import rail_fence_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  rail_fence_sched_if.slave  bus
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d, rd_q, rd_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [DATA_W-1:0] mem_q [MAX_LEN];
  logic              cfg_ok, cfg_hs, in_hs, out_hs, last, enc, wr_en, gen_adv;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [POS_W-1:0]  pos;

`ifdef RAIL_FENCE_ENCRYPT_EN
  logic mode_q, mode_d;
  assign enc = mode_q;
`else
  assign enc = 1'b0;
`endif

  rail_pos_gen u_pos_gen (
    .clk   (clk),
    .rst   (rst),
    .start (cfg_hs),
    .len   (len_q),
    .key   (key_q),
    .adv   (gen_adv),
    .pos   (pos)
  );

  // Handshakes, buffer addressing and next-state logic.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
`ifdef RAIL_FENCE_ENCRYPT_EN
    mode_d  = mode_q;
`endif
    cfg_ok  = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN)) &&
              (bus.cfg_key != '0) && (bus.cfg_key <= KEY_W'(MAX_KEY));
    cfg_hs  = bus.cfg_ready && bus.cfg_valid && cfg_ok;
    in_hs   = bus.in_ready && bus.in_valid;
    out_hs  = bus.out_valid && bus.out_ready;
    last    = (rd_q == len_q - LEN_W'(1));
    gen_adv = enc ? out_hs : in_hs;
    wr_en   = in_hs && (enc || (pos < {1'b0, len_q}));
    wr_addr = enc ? cnt_q[ADDR_W-1:0] : pos[ADDR_W-1:0];
    rd_addr = enc ? pos[ADDR_W-1:0] : rd_q[ADDR_W-1:0];
    case (state_q)
      ST_IDLE: begin
        if (cfg_hs) begin
          len_d   = bus.cfg_len;
          key_d   = bus.cfg_key;
          cnt_d   = '0;
          rd_d    = '0;
`ifdef RAIL_FENCE_ENCRYPT_EN
          mode_d  = bus.cfg_mode;
`endif
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_hs) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_hs) begin
          rd_d = rd_q + LEN_W'(1);
          if (last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; the message buffer itself is never reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
`ifdef RAIL_FENCE_ENCRYPT_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
`ifdef RAIL_FENCE_ENCRYPT_EN
      mode_q  <= mode_d;
`endif
    end
  end

  // Message buffer write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= bus.in_data;
  end

  assign bus.cfg_ready = !rst && (state_q == ST_IDLE);
  assign bus.cfg_err   = !rst && (state_q == ST_IDLE) && bus.cfg_valid && !cfg_ok;
  assign bus.in_ready  = !rst && (state_q == ST_LOAD);
  assign bus.out_valid = !rst && (state_q == ST_DRAIN);
  assign bus.out_data  = bus.out_valid ? mem_q[rd_addr] : '0;
  assign bus.out_last  = bus.out_valid && last;
  assign bus.busy      = !rst && (state_q != ST_IDLE);

endmodule

// File: tb/tb_rail_fence_sched.sv
// tb/tb_rail_fence_sched.sv - directed self-checking bench for rail_fence_sched
module tb_rail_fence_sched;
  import rail_fence_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rail_fence_sched_if bus ();

  rail_fence_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_cfg_ready"}, 32'(bus.cfg_ready), 0);
    chk({tag, "_cfg_err"},   32'(bus.cfg_err),   0);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_out_data"},  32'(bus.out_data),  0);
    chk({tag, "_out_last"},  32'(bus.out_last),  0);
    chk({tag, "_busy"},      32'(bus.busy),      0);
  endtask

  task automatic do_cfg(input int len, input int key, input bit mode, input bit ok);
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_len   = LEN_W'(len);
    bus.cfg_key   = KEY_W'(key);
`ifdef RAIL_FENCE_ENCRYPT_EN
    bus.cfg_mode  = mode;
`else
    if (mode) $display("note: mode ignored in decrypt-only build");
`endif
    #1;
    chk("cfg_ready", 32'(bus.cfg_ready), 1);
    chk("cfg_err", 32'(bus.cfg_err), 32'(!ok));
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    #1;
    chk("busy_after_cfg", 32'(bus.busy), 32'(ok));
    chk("cfg_err_clear", 32'(bus.cfg_err), 0);
  endtask

  task automatic do_load(input string s, input int n, input bit gaps, input bit enc, input int len);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 1000) begin
      @(negedge clk);
      bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_data  = s[i];
      #1;
      if (bus.in_valid && bus.in_ready) begin
        if (!enc) chk("pos_lt_len", 32'(int'(dut.u_pos_gen.pos) < len), 1);
        i++;
      end
      guard++;
    end
    chk("load_done", i, n);
  endtask

  task automatic do_drain(input string exp, input int n, input int stall_idx);
    int j = 0;
    int stall = 0;
    int guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("out_valid_first", 32'(bus.out_valid), 1);
    while (j < n && guard < 1000) begin
      bus.out_ready = !(j == stall_idx && stall < 3);
      #1;
      if (!bus.out_ready) begin
        stall++;
        chk("stall_hold_data", 32'(bus.out_data), 32'(exp[j]));
        chk("stall_hold_last", 32'(bus.out_last), 32'(j == n - 1));
      end else if (bus.out_valid) begin
        chk("out_data", 32'(bus.out_data), 32'(exp[j]));
        chk("out_last", 32'(bus.out_last), 32'(j == n - 1));
        j++;
      end
      guard++;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    #1;
    chk("drain_done", j, n);
    chk("idle_cfg_ready", 32'(bus.cfg_ready), 1);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_out_valid", 32'(bus.out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_len   = '0;
    bus.cfg_key   = '0;
`ifdef RAIL_FENCE_ENCRYPT_EN
    bus.cfg_mode  = 1'b0;
`endif
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    @(negedge clk);
    #1;
    all_zero("in_reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_cfg_ready", 32'(bus.cfg_ready), 1);
    chk("post_reset_busy", 32'(bus.busy), 0);

    do_cfg(5, 0, 1'b0, 1'b0);
    do_cfg(0, 3, 1'b0, 1'b0);
    do_cfg(5, 9, 1'b0, 1'b0);

    do_cfg(5, 2, 1'b0, 1'b1);
    do_load("HLOEL", 5, 1'b0, 1'b0, 5);
    do_drain("HELLO", 5, -1);

    do_cfg(25, 3, 1'b0, 1'b1);
    do_load("WECRLTEERDSOEEFEAOCAIVDEN", 25, 1'b0, 1'b0, 25);
    do_drain("WEAREDISCOVEREDFLEEATONCE", 25, -1);

    do_cfg(4, 1, 1'b0, 1'b1);
    do_load("ABCD", 4, 1'b0, 1'b0, 4);
    do_drain("ABCD", 4, -1);

    do_cfg(3, 5, 1'b0, 1'b1);
    do_load("ABC", 3, 1'b0, 1'b0, 3);
    do_drain("ABC", 3, -1);

    do_cfg(5, 2, 1'b0, 1'b1);
    do_load("HLOEL", 5, 1'b1, 1'b0, 5);
    do_drain("HELLO", 5, 2);

    do_cfg(25, 3, 1'b0, 1'b1);
    do_load("WECRLTEERDSOEEFEAOCAIVDEN", 10, 1'b0, 1'b0, 25);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    all_zero("mid_load_reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_cfg_ready", 32'(bus.cfg_ready), 1);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_in_ready", 32'(bus.in_ready), 0);

    do_cfg(5, 2, 1'b0, 1'b1);
    do_load("HLOEL", 5, 1'b0, 1'b0, 5);
    do_drain("HELLO", 5, -1);

`ifdef RAIL_FENCE_ENCRYPT_EN
    do_cfg(25, 3, 1'b1, 1'b1);
    do_load("WEAREDISCOVEREDFLEEATONCE", 25, 1'b0, 1'b1, 25);
    do_drain("WECRLTEERDSOEEFEAOCAIVDEN", 25, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rail_fence_sched.md
Name: rail_fence_sched

Overview:
- Sequencing controller for the rail-fence cipher datapath.
- Accepts a per-message config (length, key), then a byte stream of ciphertext over valid/ready.
- Scatters each byte into a message buffer at its zigzag plaintext position, then drains the plaintext in order over valid/ready.
- Sits between the byte-stream source and the downstream consumer. It replaces ad-hoc stimulus driving of the rail_fence datapath.

Parameters:
- DATA_W, 8: symbol width.
- MAX_LEN, 64: maximum message length in symbols; this is the buffer depth.
- LEN_W, 7: length field width, equal to clog2(MAX_LEN+1).
- MAX_KEY, 8: maximum rail count.
- KEY_W, 4: key field width, equal to clog2(MAX_KEY+1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cfg_valid  in  1  config offered
- cfg_ready  out  1  config accepted (IDLE only)
- cfg_len  in  LEN_W  message length, 1..MAX_LEN
- cfg_key  in  KEY_W  rail count, 1..MAX_KEY
- cfg_err  out  1  one-cycle pulse: config rejected
- in_valid  in  1  input symbol valid
- in_ready  out  1  input symbol accepted
- in_data  in  DATA_W  ciphertext symbol
- out_valid  out  1  output symbol valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  plaintext symbol
- out_last  out  1  final symbol of message
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Outputs during reset: while rst=1, all outputs are 0.
- After reset: state IDLE. cfg_ready=1 from the first cycle with rst=0.
- Counters and rail registers reset to 0. Buffer contents are not reset.
- States: IDLE, LOAD, DRAIN.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid, check the config.
  - Valid config (1<=len<=MAX_LEN and 1<=key<=MAX_KEY): latch len/key; next state LOAD.
  - Invalid config: cfg_err=1 for exactly one cycle; stay in IDLE.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready writes buf[pos] <= in_data, increments cnt, and advances the position generator.
  - When cnt reaches len-1 with a handshake, next state is DRAIN.
  - in_valid=0 stalls the generator; no state is lost.
- Position generator:
  - Period p = 2(key-1).
  - Starts at rail r=0, pos=0.
  - key=1: pos = cnt.
  - Rail 0 and rail key-1: step is p.
  - Middle rails: steps alternate p-2r, then 2r, beginning with p-2r.
  - If the next pos >= len: r <= r+1, pos <= r+1, and the step phase resets.
  - Empty rails never occur before cnt reaches len. The bench asserts pos < len on every write.
  - Arithmetic is LEN_W+1 bits so overflow cannot occur.
- DRAIN:
  - out_valid=1 starting the cycle after the last input handshake.
  - out_data = buf[rd]; rd starts at 0.
  - out_last = (rd == len-1).
  - rd advances on each out_valid&&out_ready.
  - While stalled, out_data and out_last are held stable.
  - After the handshake where out_last=1, next state is IDLE; cfg_ready=1 the following cycle.
- Throughput: 1 symbol per cycle in both directions. A message takes len+len cycles minimum, plus 1 cycle for config.
- Reset mid-LOAD or mid-DRAIN: the message is aborted. Next cycle is IDLE with no output residue.
- cfg_valid outside IDLE is ignored (cfg_ready=0). in_valid outside LOAD is ignored.

Optional Feature:
- Macro: RAIL_FENCE_ENCRYPT_EN.
- With the macro defined:
  - Adds input port cfg_mode (1 bit), latched together with the config. 0 = decrypt, 1 = encrypt.
  - Encrypt LOAD writes buf[cnt] sequentially.
  - Encrypt DRAIN reads buf[pos] using the position generator, advanced on output handshakes.
  - The result is ciphertext order.
- Without the macro: the port is absent and behaviour is decrypt-only.

Decomposition:
- Package rail_fence_pkg contains:
  - state encoding constants ST_IDLE=0, ST_LOAD=1, ST_DRAIN=2;
  - default widths;
  - the period helper function.
- Sub-module rail_pos_gen, the zigzag position generator. Ports: clk, rst, start, len, key, adv, pos.
- The controller instantiates rail_pos_gen once and shares it between LOAD (decrypt) and DRAIN (encrypt).

Test Plan:
- Config len=25, key=3, then ciphertext "WECRLTEERDSOEEFEAOCAIVDEN" -> output "WEAREDISCOVEREDFLEEATONCE", out_last on the 25th symbol, then IDLE.
- len=5, key=2, "HLOEL" -> "HELLO". len=4, key=1, "ABCD" -> "ABCD". len=3, key=5, "ABC" -> "ABC".
- Config key=0, then len=0, then key=9 -> cfg_err pulses once each, busy stays 0, and the next valid config is accepted.
- HELLO case with random in_valid gaps and out_ready deasserted for 3 cycles on symbol 2 -> output still "HELLO" and out_data holds 'L' across the stall.
- rst asserted after 10 symbols of the 25-symbol message -> all outputs 0 the next cycle, then idle with cfg_ready=1. A following full HELLO message decodes correctly.
- With RAIL_FENCE_ENCRYPT_EN: cfg_mode=1, len=25, key=3, input "WEAREDISCOVEREDFLEEATONCE" -> output "WECRLTEERDSOEEFEAOCAIVDEN".
